// File: rtl/mem_cmd_splitter.sv
// Splits one memory command into bursts of at most MAX_CHUNK bytes and hands
// them out round-robin over NUM_CH command channels.
module mem_cmd_splitter #(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned LEN_WIDTH      = 32,
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned MAX_CHUNK      = 4096,
  parameter bit          BOUNDARY_SPLIT = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           s_cmd_valid,
  output logic                           s_cmd_ready,
  input  logic [ADDR_WIDTH-1:0]          s_cmd_address,
  input  logic [LEN_WIDTH-1:0]           s_cmd_length,
  output logic [NUM_CH-1:0]              m_cmd_valid,
  input  logic [NUM_CH-1:0]              m_cmd_ready,
  output logic [NUM_CH*ADDR_WIDTH-1:0]   m_cmd_address,
  output logic [NUM_CH*LEN_WIDTH-1:0]    m_cmd_length,
  output logic [NUM_CH-1:0]              m_cmd_last,
  output logic                           busy
);

  localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [LEN_WIDTH-1:0]  cur_len;
  logic [CHW-1:0]        ch_ptr;

  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic [LEN_WIDTH-1:0]  nxt_rem;
  logic [LEN_WIDTH-1:0]  nxt_len;
  logic [CHW-1:0]        nxt_ptr;
  logic [CHW-1:0]        load_ptr;

  function automatic logic [LEN_WIDTH-1:0] calc_chunk(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [LEN_WIDTH-1:0]  rem
  );
    logic [LEN_WIDTH-1:0] lim;
    if (BOUNDARY_SPLIT)
      lim = LEN_WIDTH'(MAX_CHUNK) - LEN_WIDTH'(addr & ADDR_WIDTH'(MAX_CHUNK - 1));
    else
      lim = LEN_WIDTH'(MAX_CHUNK);
    return (rem < lim) ? rem : lim;
  endfunction

  // cur_addr/remaining/cur_len describe the burst currently presented; the
  // next burst is derived from them so it can be loaded on the handshake edge.
  always_comb begin
    nxt_ptr = (NUM_CH == 1) ? '0 : ch_ptr + CHW'(1);
    if (state == IDLE) begin
      nxt_addr = s_cmd_address;
      nxt_rem  = s_cmd_length;
      load_ptr = ch_ptr;
    end else begin
      nxt_addr = cur_addr + ADDR_WIDTH'(cur_len);
      nxt_rem  = remaining - cur_len;
      load_ptr = nxt_ptr;
    end
    nxt_len = calc_chunk(nxt_addr, nxt_rem);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      s_cmd_ready   <= 1'b0;
      cur_addr      <= '0;
      remaining     <= '0;
      cur_len       <= '0;
      ch_ptr        <= '0;
      m_cmd_valid   <= '0;
      m_cmd_address <= '0;
      m_cmd_length  <= '0;
      m_cmd_last    <= '0;
    end else begin
      case (state)
        IDLE: begin
          s_cmd_ready <= 1'b1;
          if (s_cmd_valid && s_cmd_ready && (s_cmd_length != '0)) begin
            state                                          <= ISSUE;
            s_cmd_ready                                    <= 1'b0;
            cur_addr                                       <= nxt_addr;
            remaining                                      <= nxt_rem;
            cur_len                                        <= nxt_len;
            m_cmd_valid                                    <= '0;
            m_cmd_valid[load_ptr]                          <= 1'b1;
            m_cmd_address[load_ptr*ADDR_WIDTH +: ADDR_WIDTH] <= nxt_addr;
            m_cmd_length[load_ptr*LEN_WIDTH +: LEN_WIDTH]    <= nxt_len;
            m_cmd_last[load_ptr]                           <= (nxt_len == nxt_rem);
          end
        end
        ISSUE: begin
          if (m_cmd_ready[ch_ptr]) begin
            ch_ptr      <= nxt_ptr;
            m_cmd_valid <= '0;
            if (cur_len == remaining) begin
              state       <= IDLE;
              s_cmd_ready <= 1'b1;
            end else begin
              cur_addr                                         <= nxt_addr;
              remaining                                        <= nxt_rem;
              cur_len                                          <= nxt_len;
              m_cmd_valid[load_ptr]                            <= 1'b1;
              m_cmd_address[load_ptr*ADDR_WIDTH +: ADDR_WIDTH] <= nxt_addr;
              m_cmd_length[load_ptr*LEN_WIDTH +: LEN_WIDTH]    <= nxt_len;
              m_cmd_last[load_ptr]                             <= (nxt_len == nxt_rem);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == ISSUE);

endmodule

// File: doc/mem_cmd_splitter.md
# mem_cmd_splitter

Parametrised successor to the single-channel memory command path: accepts one memory read/write command (64-bit byte address, 32-bit byte length) and splits it into bursts of at most `MAX_CHUNK` bytes. Bursts are distributed round-robin over `NUM_CH` output command channels, one per memory bank or engine group.

- Optional split at `MAX_CHUNK`-aligned address boundaries, so no burst crosses a page or bank stripe.
- Sits between the SGD model/dataset fetch logic and the per-bank memory command ports.

## Interface
Parameters:
- `ADDR_WIDTH`, 64, byte-address width.
- `LEN_WIDTH`, 32, byte-length width.
- `NUM_CH`, 2, number of output channels; power of 2, at least 1.
- `MAX_CHUNK`, 4096, maximum burst in bytes; power of 2, at most 2^(LEN_WIDTH-1).
- `BOUNDARY_SPLIT`, 1.
  - 1: bursts also end at `MAX_CHUNK`-aligned addresses.
  - 0: bursts are split by length only.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_cmd_valid`  in  1  input command valid.
- `s_cmd_ready`  out  1  input command ready.
- `s_cmd_address`  in  ADDR_WIDTH  start byte address.
- `s_cmd_length`  in  LEN_WIDTH  total byte length.
- `m_cmd_valid`  out  NUM_CH  per-channel burst valid.
- `m_cmd_ready`  in  NUM_CH  per-channel burst ready.
- `m_cmd_address`  out  NUM_CH*ADDR_WIDTH  burst address; channel i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `m_cmd_length`  out  NUM_CH*LEN_WIDTH  burst length; same slicing as `m_cmd_address`.
- `m_cmd_last`  out  NUM_CH  marks the final burst of the original command.
- `busy`  out  1  high while a command is being split.

## Operation
Two-state FSM: IDLE and ISSUE.

IDLE:
- `s_cmd_ready`=1.
- On handshake with length 0: the command is consumed, nothing is emitted, the FSM stays in IDLE.
- On handshake with length > 0: latch `cur_addr`=address and `remaining`=length, compute the first burst into the output registers, go to ISSUE.

ISSUE:
- `s_cmd_ready`=0.
- Exactly one bit of `m_cmd_valid` is high: bit `ch_ptr`.
- Only slice `ch_ptr` is updated; the other slices hold their last values (don't-care).

Burst length:
- `BOUNDARY_SPLIT`=1: `chunk` = min(`remaining`, `MAX_CHUNK` − `cur_addr`[log2(MAX_CHUNK)-1:0]).
- `BOUNDARY_SPLIT`=0: `chunk` = min(`remaining`, `MAX_CHUNK`).
- `m_cmd_last` = (`chunk` == `remaining`).

On handshake of `m_cmd_valid[ch_ptr]` & `m_cmd_ready[ch_ptr]`:
- `cur_addr` += `chunk`, modulo 2^ADDR_WIDTH (silent wrap, no error).
- `remaining` −= `chunk`.
- `ch_ptr` = (`ch_ptr`+1) mod `NUM_CH`.
- If the burst was last, go to IDLE; otherwise load the next burst into the output registers the same cycle.

Other rules:
- `ch_ptr` persists across commands; only reset clears it to 0.
- `m_cmd_ready` bits of non-selected channels are ignored.
- `busy` = (state == ISSUE).

Reset (`rst_n` low, asynchronous):
- State IDLE, `ch_ptr`=0, `m_cmd_valid`=0, `m_cmd_last`=0, `m_cmd_address`/`m_cmd_length`=0, `busy`=0.
- `s_cmd_ready`=0 while in reset, 1 from the first edge after release.
- Reset mid-command discards the remaining bursts; no partial state survives.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Input accepted at edge T: first burst valid at T+1.
- A command of N bursts with ready held high: valid in cycles T+1..T+N, one burst per cycle.
- `s_cmd_ready` rises at T+N+1, so back-to-back commands incur one idle cycle.
- Valid/data stability: once `m_cmd_valid[i]` is asserted, `m_cmd_address`, `m_cmd_length` and `m_cmd_last` slice i stay stable until the handshake; valid never drops without a handshake.
- Backpressure on the selected channel stalls the whole block; no reordering, no skipping to another channel.
- Critical path: `MAX_CHUNK` offset subtract plus min compare (LEN_WIDTH bits) plus ADDR_WIDTH add. A single cycle is required at 250 MHz for the default widths.

## Test plan
- Boundary split (`NUM_CH`=2, `MAX_CHUNK`=4096, `BOUNDARY_SPLIT`=1), ready high; cmd (0x1F00, 0x2200) -> four bursts:
  - (0x1F00, 0x100, ch0)
  - (0x2000, 0x1000, ch1)
  - (0x3000, 0x1000, ch0)
  - (0x4000, 0x100, ch1, last)
  - Bursts in consecutive cycles starting T+1; `s_cmd_ready` at T+5.
- Same cmd with `BOUNDARY_SPLIT`=0 -> three bursts:
  - (0x1F00, 0x1000, ch0)
  - (0x2F00, 0x1000, ch1)
  - (0x3F00, 0x200, ch0, last)
- Zero length: cmd (0x80, 0) -> handshake accepted; `m_cmd_valid` stays 0, `busy` stays 0, `ch_ptr` unchanged.
- Backpressure: during the second burst of scenario 1, hold `m_cmd_ready[1]`=0 for 5 cycles and pulse `m_cmd_ready[0]` -> valid[1] held; address 0x2000 and length 0x1000 stable; no progress; valid[0] stays 0.
- Round-robin persistence and wrap: cmds (0x0, 64), (0x40, 64), then (0xFFFF_FFFF_FFFF_FF00, 0x200) -> bursts:
  - ch0, ch1
  - then (…FF00, 0x100, ch0)
  - then (0x0, 0x100, ch1, last)
- Reset mid-command: assert `rst_n`=0 after the first burst of scenario 1 -> all `m_cmd_valid`=0 immediately (asynchronous). After release: `s_cmd_ready`=1, and the next cmd (0x0, 64) issues on ch0.
